td4_sequencer: RTL and testbench
================================

# td4_sequencer

Multi-cycle control sequencer for the 4-bit TD4 datapath. Latches each 8-bit instruction word from program ROM and decodes it. Drives the load/enable strobes of the A, B, OUT and PC registers, the ALU source-mux select and the immediate field. Owns the carry flag used by JNC. Sits between the ROM output and the register/ALU datapath, one instruction per two clocks, gated by a run/step handshake.

## Interface
- DATA_W, 4, datapath and immediate width; only 4 is supported.
- CLK  in  1  system clock, rising edge.
- CLR  in  1  asynchronous, active-low reset.
- run  in  1  1 = free-run; 0 = hold in FETCH after current instruction completes.
- rom_data  in  8  instruction word addressed by current PC value; [7:4] opcode, [3:0] immediate.
- alu_carry  in  1  carry-out of datapath adder (A/B/IN/zero source + im).
- sel  out  2  ALU source select: 00 A, 01 B, 10 IN port, 11 zero.
- im  out  DATA_W  immediate field of latched instruction (IR[3:0]).
- ld_a, ld_b, ld_out  out  1 each  register load strobes.
- pc_inc  out  1  PC increment strobe.
- pc_load  out  1  PC load-from-adder strobe; never high together with pc_inc.
- c_flag  out  1  current carry flag.
- done  out  1  one-cycle pulse in the EXEC cycle of every instruction.

## Operation
- States: FETCH, EXEC. FETCH: if run=1, IR <= rom_data, go to EXEC; else stay, IR unchanged. EXEC: assert strobes per decode, always return to FETCH.
- All strobes and sel are combinational from (state==EXEC, IR); zero in FETCH. im = IR[3:0] in both states.
- Decode (opcode: sel, strobe): 0000 ADD A,Im: 00, ld_a. 0001 MOV A,B: 01, ld_a. 0010 IN A: 10, ld_a. 0011 MOV A,Im: 11, ld_a. 0100 MOV B,A: 00, ld_b. 0101 ADD B,Im: 01, ld_b. 0110 IN B: 10, ld_b. 0111 MOV B,Im: 11, ld_b. 1001 OUT B: 01, ld_out. 1011 OUT Im: 11, ld_out. 1111 JMP Im: 11, pc_load. 1110 JNC Im: 11, pc_load if c_flag=0 else pc_inc.
- Non-jump defined opcodes also assert pc_inc.
- MOV forms rely on im=0 in the encoding; the sequencer does not force im.
- Undefined opcodes (1000, 1010, 1100, 1101): NOP. sel=00, only pc_inc, c_flag unchanged.
- Carry: at the EXEC→FETCH edge, c_flag <= alu_carry for every defined opcode including jumps (JMP/JNC select zero+im, so carry is 0). JNC tests c_flag as it was before that update.

## Timing
- Reset (CLR=0, async): state=FETCH, IR=8'h00, c_flag=0. All strobes, sel=00, done=0 immediately. im=0.
- Latency: 2 cycles/instruction. Strobes valid for exactly the EXEC cycle, consumed by datapath on the edge ending EXEC.
- run sampled only in FETCH; dropping run during EXEC completes that instruction, then holds.
- run pulsed high for 1 cycle in FETCH executes exactly one instruction (single-step).
- CLR asserted during EXEC: strobes drop combinationally in the same cycle, no register loads, c_flag cleared.
- PC wrap (1111→0000) is the PC's concern; the sequencer is unaffected.

## Structure
- Package td4_pkg: opcode localparams, state enum {FETCH, EXEC}, sel encoding constants, control struct (sel, ld_a, ld_b, ld_out, pc_inc, pc_load, upd_c).
- Sub-module td4_decode: purely combinational (opcode, c_flag) → control struct. td4_sequencer holds FSM, IR, c_flag and gates the struct with state==EXEC.

## Test plan
- Reset: CLR=0 mid-EXEC of 0000_0101 → all strobes 0 same cycle, c_flag=0, state FETCH after release.
- ADD A,Im: rom_data=8'h05, run=1 → EXEC cycle: sel=00, im=5, ld_a=1, pc_inc=1, done=1; alu_carry=1 → c_flag=1 next cycle.
- JNC: c_flag=1, rom_data=8'hE3 → pc_inc=1, pc_load=0, c_flag→0. Repeat with c_flag=0 → pc_load=1, im=3.
- Step: run=0 for 10 cycles → no strobes, IR held. 1-cycle run pulse → exactly one done pulse.
- Each opcode 0000–1111 swept → sel/strobe pattern per decode list. Undefined opcodes give pc_inc only and unchanged c_flag.
- OUT Im: rom_data=8'hB9 → sel=11, im=9, ld_out=1, pc_inc=1; ld_a=ld_b=0.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 control sequencer: opcodes, FSM states, ALU source
// select codes and the decoded control bundle.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_e;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef struct packed {
    logic [1:0] sel;
    logic       ld_a;
    logic       ld_b;
    logic       ld_out;
    logic       pc_inc;
    logic       pc_load;
    logic       upd_c;
  } ctrl_t;

endpackage

// File: rtl/td4_decode.sv
// Combinational instruction decoder: opcode plus current carry flag to control bundle.
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       c_flag,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.pc_inc = 1'b1;
    ctrl.upd_c  = 1'b1;
    case (opcode)
      OP_ADD_A:  begin ctrl.sel = SEL_A;    ctrl.ld_a   = 1'b1; end
      OP_MOV_AB: begin ctrl.sel = SEL_B;    ctrl.ld_a   = 1'b1; end
      OP_IN_A:   begin ctrl.sel = SEL_IN;   ctrl.ld_a   = 1'b1; end
      OP_MOV_AI: begin ctrl.sel = SEL_ZERO; ctrl.ld_a   = 1'b1; end
      OP_MOV_BA: begin ctrl.sel = SEL_A;    ctrl.ld_b   = 1'b1; end
      OP_ADD_B:  begin ctrl.sel = SEL_B;    ctrl.ld_b   = 1'b1; end
      OP_IN_B:   begin ctrl.sel = SEL_IN;   ctrl.ld_b   = 1'b1; end
      OP_MOV_BI: begin ctrl.sel = SEL_ZERO; ctrl.ld_b   = 1'b1; end
      OP_OUT_B:  begin ctrl.sel = SEL_B;    ctrl.ld_out = 1'b1; end
      OP_OUT_I:  begin ctrl.sel = SEL_ZERO; ctrl.ld_out = 1'b1; end
      OP_JMP: begin
        ctrl.sel     = SEL_ZERO;
        ctrl.pc_inc  = 1'b0;
        ctrl.pc_load = 1'b1;
      end
      // Jump taken only when no carry was produced by the previous instruction.
      OP_JNC: begin
        ctrl.sel     = SEL_ZERO;
        ctrl.pc_inc  = c_flag;
        ctrl.pc_load = ~c_flag;
      end
      default: begin
        ctrl.sel   = SEL_A;
        ctrl.upd_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// Two-cycle FETCH/EXEC control sequencer for the TD4 datapath; owns IR and the carry flag.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              run,
  input  logic [7:0]        rom_data,
  input  logic              alu_carry,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] im,
  output logic              ld_a,
  output logic              ld_b,
  output logic              ld_out,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              c_flag,
  output logic              done
);

  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       c_flag_q, c_flag_d;
  ctrl_t      dec;
  logic       in_exec;

  td4_decode u_decode (
    .opcode (ir_q[7:4]),
    .c_flag (c_flag_q),
    .ctrl   (dec)
  );

  assign in_exec = (state_q == EXEC);

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    c_flag_d = c_flag_q;
    unique case (state_q)
      FETCH: begin
        if (run) begin
          ir_d    = rom_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        if (dec.upd_c) c_flag_d = alu_carry;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= FETCH;
      ir_q     <= 8'h00;
      c_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      c_flag_q <= c_flag_d;
    end
  end

  // Async reset forces FETCH, so the strobes fall in the same cycle CLR asserts.
  assign sel     = in_exec ? dec.sel : SEL_A;
  assign ld_a    = in_exec & dec.ld_a;
  assign ld_b    = in_exec & dec.ld_b;
  assign ld_out  = in_exec & dec.ld_out;
  assign pc_inc  = in_exec & dec.pc_inc;
  assign pc_load = in_exec & dec.pc_load;
  assign done    = in_exec;
  assign im      = ir_q[DATA_W-1:0];
  assign c_flag  = c_flag_q;

endmodule

// File: tb/tb_td4_sequencer.sv
// Directed self-checking bench for td4_sequencer: decode sweep, carry/JNC, step and reset.
module tb_td4_sequencer;

  logic       clk;
  logic       clr;
  logic       run;
  logic [7:0] rom_data;
  logic       alu_carry;
  logic [1:0] sel;
  logic [3:0] im;
  logic       ld_a, ld_b, ld_out, pc_inc, pc_load, c_flag, done;

  int n_cmp = 0;
  int n_err = 0;

  td4_sequencer #(.DATA_W(4)) dut (
    .CLK       (clk),
    .CLR       (clr),
    .run       (run),
    .rom_data  (rom_data),
    .alu_carry (alu_carry),
    .sel       (sel),
    .im        (im),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .ld_out    (ld_out),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .c_flag    (c_flag),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {ld_a, ld_b, ld_out, pc_inc, pc_load};
  endfunction

  // Starts at a negedge in FETCH; executes one instruction and returns at a negedge in FETCH.
  // estr = {ld_a, ld_b, ld_out, pc_inc, pc_load}
  task automatic run_vec(input logic [7:0] instr, input logic carry, input logic [1:0] esel,
                         input logic [4:0] estr, input logic ec);
    rom_data  = instr;
    alu_carry = carry;
    run       = 1'b1;
    @(posedge clk); #1;
    run      = 1'b0;
    rom_data = 8'hFF;
    @(negedge clk);
    check($sformatf("sel_%02h", instr), 32'(sel), 32'(esel));
    check($sformatf("strobes_%02h", instr), 32'(strobes()), 32'(estr));
    check($sformatf("im_%02h", instr), 32'(im), 32'(instr[3:0]));
    check($sformatf("done_%02h", instr), 32'(done), 32'd1);
    @(posedge clk); #1;
    check($sformatf("cflag_%02h", instr), 32'(c_flag), 32'(ec));
    check($sformatf("idle_%02h", instr), 32'({sel, strobes(), done}), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int dcount;
    clr       = 1'b0;
    run       = 1'b0;
    rom_data  = 8'h00;
    alu_carry = 1'b0;
    #2;
    check("rst_outputs", 32'({sel, strobes(), done, c_flag}), 32'd0);
    check("rst_im", 32'(im), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    // Decode sweep with chained carry flag; JNC exercised with carry both set and clear.
    run_vec(8'h05, 1'b1, 2'b00, 5'b10010, 1'b1);
    run_vec(8'hE3, 1'b0, 2'b11, 5'b00010, 1'b0);
    run_vec(8'hE3, 1'b0, 2'b11, 5'b00001, 1'b0);
    run_vec(8'h10, 1'b1, 2'b01, 5'b10010, 1'b1);
    run_vec(8'h20, 1'b0, 2'b10, 5'b10010, 1'b0);
    run_vec(8'h30, 1'b1, 2'b11, 5'b10010, 1'b1);
    run_vec(8'h8F, 1'b0, 2'b00, 5'b00010, 1'b1);
    run_vec(8'h40, 1'b0, 2'b00, 5'b01010, 1'b0);
    run_vec(8'h51, 1'b1, 2'b01, 5'b01010, 1'b1);
    run_vec(8'hA0, 1'b0, 2'b00, 5'b00010, 1'b1);
    run_vec(8'h60, 1'b0, 2'b10, 5'b01010, 1'b0);
    run_vec(8'h70, 1'b1, 2'b11, 5'b01010, 1'b1);
    run_vec(8'hC0, 1'b0, 2'b00, 5'b00010, 1'b1);
    run_vec(8'h90, 1'b0, 2'b01, 5'b00110, 1'b0);
    run_vec(8'hD0, 1'b1, 2'b00, 5'b00010, 1'b0);
    run_vec(8'hB9, 1'b1, 2'b11, 5'b00110, 1'b1);
    run_vec(8'hF7, 1'b0, 2'b11, 5'b00001, 1'b0);
    run_vec(8'hF2, 1'b1, 2'b11, 5'b00001, 1'b1);
    run_vec(8'hE5, 1'b0, 2'b11, 5'b00010, 1'b0);

    // Hold: run low for 10 cycles, IR (last im=5) must not follow rom_data.
    rom_data = 8'h3A;
    dcount   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dcount += int'({ld_a | ld_b | ld_out | pc_inc | pc_load | done});
    end
    check("hold_strobes", 32'(dcount), 32'd0);
    check("hold_im", 32'(im), 32'd5);

    // Single-step: one-cycle run pulse gives exactly one done.
    run = 1'b1;
    @(posedge clk); #1;
    run    = 1'b0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dcount += int'(done);
    end
    check("step_done_count", 32'(dcount), 32'd1);
    check("step_im", 32'(im), 32'hA);

    // Free-run, then drop run during an EXEC cycle: 4 instructions total.
    rom_data  = 8'h30;
    alu_carry = 1'b0;
    run       = 1'b1;
    dcount    = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      dcount += int'(done);
      if (i == 7) run = 1'b0;
    end
    check("freerun_done_count", 32'(dcount), 32'd4);

    // Reset asserted in the middle of EXEC of ADD A,5 with carry already set.
    run_vec(8'h05, 1'b1, 2'b00, 5'b10010, 1'b1);
    rom_data  = 8'h05;
    alu_carry = 1'b1;
    run       = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    @(negedge clk);
    check("pre_rst_done", 32'(done), 32'd1);
    clr = 1'b0;
    #1;
    check("rst_exec_strobes", 32'({sel, strobes(), done}), 32'd0);
    check("rst_exec_cflag", 32'(c_flag), 32'd0);
    check("rst_exec_im", 32'(im), 32'd0);
    @(negedge clk);
    clr    = 1'b1;
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dcount += int'(done);
    end
    check("post_rst_idle", 32'(dcount), 32'd0);
    run_vec(8'h05, 1'b0, 2'b00, 5'b10010, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
